// File: rtl/multi_debounce.sv
// multi_debounce: N independent counter-based debouncers with edge pulses and busy flags (optional MULTI_DEBOUNCE_SYNC_EN adds 2-flop input synchronisers)
module multi_debounce #(
  parameter int N         = 4,
  parameter int THRESH    = 2097152,
  parameter int CNT_W     = 22,
  parameter bit RST_LEVEL = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] din,
  output logic [N-1:0] dout,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall,
  output logic [N-1:0] busy
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(THRESH - 1);
  logic [N-1:0] s;
`ifdef MULTI_DEBOUNCE_SYNC_EN
  logic [N-1:0] sync1, sync2;
  // two-flop synchroniser per channel, reset to the idle output level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= {N{RST_LEVEL}};
      sync2 <= {N{RST_LEVEL}};
    end else begin
      sync1 <= din;
      sync2 <= sync1;
    end
  end
  assign s = sync2;
`else
  assign s = din;
`endif
  genvar i;
  for (i = 0; i < N; i++) begin : g_ch
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic hit, q, r, f, b;
    // a differing sample either extends the run or, at the last count, is accepted
    always_comb begin
      hit    = (s[i] != q) && (cnt == LAST);
      cnt_nx = (s[i] == q || hit) ? '0 : cnt + 1'b1;
    end
    // per-channel state: count, stable level, edge pulses and busy flag
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt <= '0;
        q   <= RST_LEVEL;
        r   <= 1'b0;
        f   <= 1'b0;
        b   <= 1'b0;
      end else begin
        cnt <= cnt_nx;
        b   <= |cnt_nx;
        r   <= hit && s[i];
        f   <= hit && !s[i];
        if (hit) q <= s[i];
      end
    end
    assign dout[i] = q;
    assign rise[i] = r;
    assign fall[i] = f;
    assign busy[i] = b;
  end
endmodule

// File: tb/tb_multi_debounce.sv
// tb_multi_debounce: window-based reference model with per-cycle compare, directed literal checks and randomized bouncing
module tb_multi_debounce;
  localparam int N = 2;
  localparam int T = 4;
`ifdef MULTI_DEBOUNCE_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] din = '0;
  logic [N-1:0] dout, rise, fall, busy;
  int compared = 0;
  int mismatched = 0;

  multi_debounce #(.N(N), .THRESH(T), .CNT_W(3), .RST_LEVEL(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .dout(dout), .rise(rise), .fall(fall), .busy(busy)
  );

  always #5 clk = ~clk;

  // reference: a change is accepted once the last T samples all equal the opposite of the stable level
  logic [N-1:0] m_dout, m_rise, m_fall, m_busy;
  logic [N-1:0] p1, p2, smp;
  logic [T-1:0] win [N];
  int nv [N];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_dout = '0; m_rise = '0; m_fall = '0; m_busy = '0; p1 = '0; p2 = '0;
      for (int c = 0; c < N; c++) begin
        win[c] = '0;
        nv[c] = 0;
      end
    end else begin
      smp = (LAT == 2) ? p2 : din;
      p2 = p1;
      p1 = din;
      for (int c = 0; c < N; c++) begin
        logic acc;
        win[c] = {win[c][T-2:0], smp[c]};
        if (nv[c] < T) nv[c]++;
        acc = (nv[c] == T) && (win[c] == {T{~m_dout[c]}});
        m_busy[c] = (smp[c] != m_dout[c]) && !acc;
        m_rise[c] = acc && smp[c];
        m_fall[c] = acc && !smp[c];
        if (acc) m_dout[c] = smp[c];
      end
    end
  end

  // compare every cycle, away from the active edge
  always @(negedge clk) begin
    compared++;
    if ({dout, rise, fall, busy} !== {m_dout, m_rise, m_fall, m_busy}) begin
      mismatched++;
      $display("FAIL cycle t=%0t dut dout=%b rise=%b fall=%b busy=%b model dout=%b rise=%b fall=%b busy=%b",
               $time, dout, rise, fall, busy, m_dout, m_rise, m_fall, m_busy);
    end
  end

  task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic step(input logic [N-1:0] v);
    din = v;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("reset dout", dout, 2'b00);
    chk("reset busy", busy, 2'b00);
    chk("reset rise", rise, 2'b00);
    chk("reset fall", fall, 2'b00);
    din = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    @(posedge clk);
    #1;
    do_reset();
    // both channels held high: accepted at the T-th edge (plus sync latency)
    for (int k = 0; k < LAT; k++) step(2'b11);
    for (int k = 0; k < T - 1; k++) begin
      step(2'b11);
      chk("hold dout", dout, 2'b00);
      chk("hold busy", busy, 2'b11);
    end
    step(2'b11);
    chk("accept dout", dout, 2'b11);
    chk("accept rise", rise, 2'b11);
    chk("accept fall", fall, 2'b00);
    chk("accept busy", busy, 2'b00);
    step(2'b11);
    chk("rise one cycle", rise, 2'b00);
    // channel 1 falls while channel 0 bounces
    for (int k = 0; k < T + LAT; k++) step({1'b0, k[0] ? 1'b1 : 1'b0});
    chk("fall dout", dout, 2'b01);
    chk("fall pulse", fall, 2'b10);
    chk("fall rise", rise, 2'b00);
    // bounce restarts timing on channel 0
    do_reset();
    begin
      logic [7:0] seq;
      seq = 8'b11110111;
      for (int k = 0; k < 8; k++) step({1'b0, seq[k]});
    end
    for (int k = 0; k < LAT; k++) step(2'b01);
    chk("bounce dout", dout, 2'b01);
    chk("bounce rise", rise, 2'b01);
    // reset mid-count discards the partial count
    do_reset();
    for (int k = 0; k < LAT + T - 1; k++) step(2'b11);
    chk("midcount busy", busy, 2'b11);
    do_reset();
    for (int k = 0; k < LAT + T - 1; k++) step(2'b11);
    chk("post reset dout", dout, 2'b00);
    step(2'b11);
    chk("post reset accept", dout, 2'b11);
    chk("post reset rise", rise, 2'b11);
    // randomized bouncing with occasional resets
    for (int k = 0; k < 3000; k++) begin
      logic [N-1:0] v;
      v = din;
      for (int c = 0; c < N; c++) if ($urandom_range(0, 5) == 0) v[c] = ~v[c];
      if ($urandom_range(0, 399) == 0) do_reset();
      else step(v);
    end
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
